// File: rtl/calf_pkg.sv
// Shared widths, control-word field offsets and port indices for the CALF router.
package calf_pkg;

  localparam int unsigned CONTROL_W = 16;
  localparam int unsigned DATA_W    = 32;

  // Control word layout: [15] valid, [14:11] dest_x, [10:7] dest_y, [6:0] age.
  localparam int unsigned VALID   = 15;
  localparam int unsigned DX_LSB  = 11;
  localparam int unsigned DY_LSB  = 7;
  localparam int unsigned AGE_LSB = 0;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned AGE_W   = 7;

  localparam logic [AGE_W-1:0] AGE_MAX = 7'd127;

  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_S = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned NUM_NET   = 4;

  // Age grows by one per hop and sticks at the maximum.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    return (age == AGE_MAX) ? AGE_MAX : age + 7'd1;
  endfunction

endpackage

// File: rtl/calf_if.sv
// Flit bus for the five router ports: control/data in and registered control/data out.
interface calf_if
  import calf_pkg::*;
();

  logic [NUM_PORTS-1:0][CONTROL_W-1:0] ci;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    di;
  logic [NUM_PORTS-1:0][CONTROL_W-1:0] co;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    dout;

  // master: the links/node feeding the router; slave: the router itself.
  modport master (output ci, di, input co, dout);
  modport slave  (input ci, di, output co, dout);

endinterface

// File: rtl/calf_route.sv
// Combinational XY dimension-order route compute: X first, then Y, else local.
module calf_route
  import calf_pkg::*;
#(
  parameter logic [COORD_W-1:0] MY_X = 4'd0,
  parameter logic [COORD_W-1:0] MY_Y = 4'd0
) (
  input  logic [COORD_W-1:0] dest_x_i,
  input  logic [COORD_W-1:0] dest_y_i,
  output logic [2:0]         port_o
);

  // Resolve X offset before Y; an exact match ejects locally.
  always_comb begin
    port_o = P_L;
    if (dest_x_i > MY_X)      port_o = P_E;
    else if (dest_x_i < MY_X) port_o = P_W;
    else if (dest_y_i > MY_Y) port_o = P_S;
    else if (dest_y_i < MY_Y) port_o = P_N;
  end

endmodule

// File: rtl/tb_calf_router.sv
// Bufferless CALF deflection router: oldest-first greedy port allocation, one-entry
// injection holding register, registered outputs.
module tb_calf_router
  import calf_pkg::*;
#(
  parameter logic [COORD_W-1:0] MY_X = 4'd0,
  parameter logic [COORD_W-1:0] MY_Y = 4'd0
) (
  input  logic  clk,
  input  logic  rst_n,
  calf_if.slave bus
);

  logic                 hold_vld_q;
  logic [CONTROL_W-1:0] hold_ctrl_q;
  logic [DATA_W-1:0]    hold_data_q;
  logic                 hold_vld_d;
  logic [CONTROL_W-1:0] hold_ctrl_d;
  logic [DATA_W-1:0]    hold_data_d;

  logic [NUM_PORTS-1:0][CONTROL_W-1:0] co_q, co_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    do_q, do_d;

  // Inject candidate: the held flit if any, else a fresh flit bypasses the holding register.
  logic                 cand_vld;
  logic [CONTROL_W-1:0] cand_ctrl;
  logic [DATA_W-1:0]    cand_data;

  logic [NUM_PORTS-1:0][CONTROL_W-1:0] rt_ctrl;
  logic [2:0]                          rt_port [NUM_PORTS];
  logic [NUM_NET-1:0]                  net_vld;
  logic [1:0]                          rank    [NUM_NET];
  logic [NUM_PORTS-1:0]                out_vld;
  logic [2:0]                          out_src [NUM_PORTS];
  logic                                inj_sent;

  assign cand_vld  = hold_vld_q | bus.ci[P_L][VALID];
  assign cand_ctrl = hold_vld_q ? hold_ctrl_q : bus.ci[P_L];
  assign cand_data = hold_vld_q ? hold_data_q : bus.di[P_L];

  always_comb begin
    rt_ctrl      = bus.ci;
    rt_ctrl[P_L] = cand_ctrl;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_route
    calf_route #(
      .MY_X (MY_X),
      .MY_Y (MY_Y)
    ) u_route (
      .dest_x_i (rt_ctrl[g][DX_LSB +: COORD_W]),
      .dest_y_i (rt_ctrl[g][DY_LSB +: COORD_W]),
      .port_o   (rt_port[g])
    );
  end

  // Priority rank per network flit: number of valid flits that are older, or equal age on a
  // lower input index.
  always_comb begin
    for (int i = 0; i < NUM_NET; i++) begin
      net_vld[i] = bus.ci[i][VALID];
      rank[i]    = 2'd0;
    end
    for (int i = 0; i < NUM_NET; i++) begin
      for (int j = 0; j < NUM_NET; j++) begin
        if (j != i && bus.ci[j][VALID] &&
            ((bus.ci[j][AGE_LSB +: AGE_W] > bus.ci[i][AGE_LSB +: AGE_W]) ||
             (bus.ci[j][AGE_LSB +: AGE_W] == bus.ci[i][AGE_LSB +: AGE_W] && j < i))) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
    end
  end

  // Greedy allocation in rank order; the inject candidate goes last. Four network inputs
  // against four network outputs means every network flit always finds a port.
  always_comb begin
    logic assigned;
    out_vld  = '0;
    inj_sent = 1'b0;
    assigned = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) out_src[p] = 3'd0;
    for (int r = 0; r < NUM_NET; r++) begin
      for (int i = 0; i < NUM_NET; i++) begin
        if (net_vld[i] && rank[i] == 2'(r)) begin
          assigned = 1'b0;
          if (!out_vld[rt_port[i]]) begin
            out_vld[rt_port[i]] = 1'b1;
            out_src[rt_port[i]] = 3'(i);
            assigned            = 1'b1;
          end
          for (int p = 0; p < NUM_NET; p++) begin
            if (!assigned && !out_vld[p]) begin
              out_vld[p] = 1'b1;
              out_src[p] = 3'(i);
              assigned   = 1'b1;
            end
          end
        end
      end
    end
    // Injection only uses network outputs; a self-addressed inject takes any free one.
    if (cand_vld) begin
      if (rt_port[P_L] != P_L && !out_vld[rt_port[P_L]]) begin
        out_vld[rt_port[P_L]] = 1'b1;
        out_src[rt_port[P_L]] = P_L;
        inj_sent              = 1'b1;
      end
      for (int p = 0; p < NUM_NET; p++) begin
        if (!inj_sent && !out_vld[p]) begin
          out_vld[p] = 1'b1;
          out_src[p] = P_L;
          inj_sent   = 1'b1;
        end
      end
    end
  end

  // Output next-state: network hops age by one; ejected and freshly injected flits keep age.
  always_comb begin
    co_d = '0;
    do_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_vld[p]) begin
        if (out_src[p] == P_L) begin
          co_d[p] = cand_ctrl;
          do_d[p] = cand_data;
        end else begin
          co_d[p] = bus.ci[out_src[p]];
          do_d[p] = bus.di[out_src[p]];
          if (p != int'(P_L)) begin
            co_d[p][AGE_LSB +: AGE_W] = age_inc(bus.ci[out_src[p]][AGE_LSB +: AGE_W]);
          end
        end
      end
    end
  end

  // Holding register keeps an unsent candidate; new port4 flits are ignored while it is full.
  always_comb begin
    hold_vld_d  = cand_vld & ~inj_sent;
    hold_ctrl_d = cand_ctrl;
    hold_data_d = cand_data;
  end

  // State and output registers; reset drops every in-flight and held flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_ctrl_q <= '0;
      hold_data_q <= '0;
      co_q        <= '0;
      do_q        <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_ctrl_q <= hold_ctrl_d;
      hold_data_q <= hold_data_d;
      co_q        <= co_d;
      do_q        <= do_d;
    end
  end

  assign bus.co   = co_q;
  assign bus.dout = do_q;

endmodule

// File: tb/tb_tb_calf_router.sv
// Directed bench for the CALF router at MY=(1,1) with hand-computed expected outputs.
module tb_tb_calf_router;
  import calf_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [NUM_PORTS-1:0][CONTROL_W-1:0] exp_co;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    exp_do;

  calf_if bus ();

  tb_calf_router #(
    .MY_X (4'd1),
    .MY_Y (4'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CONTROL_W-1:0] mk(input int dx, input int dy, input int age);
    return {1'b1, 4'(dx), 4'(dy), 7'(age)};
  endfunction

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ci = '0;
    bus.di = '0;
  endtask

  task automatic clr_exp();
    exp_co = '0;
    exp_do = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, "_co"}, 160'(bus.co), 160'(exp_co));
    check_val({tag, "_do"}, 160'(bus.dout), 160'(exp_do));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.ci[i] = 16'($urandom);
      bus.di[i] = $urandom;
    end
    step();
    step();
    clr_exp();
    check_outs("reset");

    // Release with idle inputs: outputs stay zero.
    idle_inputs();
    rst_n = 1'b1;
    step();
    check_outs("post_reset");

    // Single flit W-in to E-out.
    bus.ci[3] = mk(2, 1, 5);
    bus.di[3] = 32'hDEADBEEF;
    step();
    idle_inputs();
    clr_exp();
    exp_co[1] = mk(2, 1, 6);
    exp_do[1] = 32'hDEADBEEF;
    check_outs("single");

    // Ejection keeps age.
    bus.ci[0] = mk(1, 1, 7);
    bus.di[0] = 32'h0000_0011;
    step();
    idle_inputs();
    clr_exp();
    exp_co[4] = mk(1, 1, 7);
    exp_do[4] = 32'h0000_0011;
    check_outs("eject");

    // Two local flits: older ejects, younger deflects to N.
    bus.ci[1] = mk(1, 1, 9);
    bus.di[1] = 32'hAAAA_0009;
    bus.ci[2] = mk(1, 1, 3);
    bus.di[2] = 32'hBBBB_0003;
    step();
    idle_inputs();
    clr_exp();
    exp_co[4] = mk(1, 1, 9);
    exp_do[4] = 32'hAAAA_0009;
    exp_co[0] = mk(1, 1, 4);
    exp_do[0] = 32'hBBBB_0003;
    check_outs("eject2");

    // Conflict on E: age 10 wins, age 4 deflects to N.
    bus.ci[0] = mk(2, 1, 10);
    bus.di[0] = 32'hC0C0_000A;
    bus.ci[2] = mk(2, 1, 4);
    bus.di[2] = 32'hD0D0_0004;
    step();
    idle_inputs();
    clr_exp();
    exp_co[1] = mk(2, 1, 11);
    exp_do[1] = 32'hC0C0_000A;
    exp_co[0] = mk(2, 1, 5);
    exp_do[0] = 32'hD0D0_0004;
    check_outs("conflict");

    // Equal ages: lower input index wins E.
    bus.ci[0] = mk(2, 1, 6);
    bus.di[0] = 32'h1111_0000;
    bus.ci[1] = mk(2, 1, 6);
    bus.di[1] = 32'h2222_0000;
    step();
    idle_inputs();
    clr_exp();
    exp_co[1] = mk(2, 1, 7);
    exp_do[1] = 32'h1111_0000;
    exp_co[0] = mk(2, 1, 7);
    exp_do[0] = 32'h2222_0000;
    check_outs("tie");

    // All four network ports busy: inject is held.
    bus.ci[0] = mk(2, 1, 1);
    bus.di[0] = 32'h0000_00E0;
    bus.ci[1] = mk(0, 1, 2);
    bus.di[1] = 32'h0000_00E1;
    bus.ci[2] = mk(1, 2, 3);
    bus.di[2] = 32'h0000_00E2;
    bus.ci[3] = mk(1, 0, 4);
    bus.di[3] = 32'h0000_00E3;
    bus.ci[4] = mk(2, 1, 20);
    bus.di[4] = 32'h0000_AAAA;
    step();
    idle_inputs();
    // Holding register full: this new flit must be ignored.
    bus.ci[4] = mk(0, 1, 30);
    bus.di[4] = 32'h0000_BBBB;
    clr_exp();
    exp_co[0] = mk(1, 0, 5);
    exp_do[0] = 32'h0000_00E3;
    exp_co[1] = mk(2, 1, 2);
    exp_do[1] = 32'h0000_00E0;
    exp_co[2] = mk(1, 2, 4);
    exp_do[2] = 32'h0000_00E2;
    exp_co[3] = mk(0, 1, 3);
    exp_do[3] = 32'h0000_00E1;
    check_outs("inj_blocked");

    step();
    idle_inputs();
    clr_exp();
    exp_co[1] = mk(2, 1, 20);
    exp_do[1] = 32'h0000_AAAA;
    check_outs("inj_release");

    step();
    clr_exp();
    check_outs("inj_ignored");

    // Immediate injection onto a free productive port.
    bus.ci[4] = mk(1, 2, 8);
    bus.di[4] = 32'h5555_0008;
    step();
    idle_inputs();
    clr_exp();
    exp_co[2] = mk(1, 2, 8);
    exp_do[2] = 32'h5555_0008;
    check_outs("inj_direct");

    // Age saturation.
    bus.ci[1] = mk(0, 1, 127);
    bus.di[1] = 32'h7F7F_7F7F;
    step();
    idle_inputs();
    clr_exp();
    exp_co[3] = mk(0, 1, 127);
    exp_do[3] = 32'h7F7F_7F7F;
    check_outs("age_sat");

    // Mid-operation reset clears outputs asynchronously and empties the holding register.
    bus.ci[0] = mk(2, 1, 1);
    bus.ci[1] = mk(0, 1, 1);
    bus.ci[2] = mk(1, 2, 1);
    bus.ci[3] = mk(1, 0, 1);
    bus.ci[4] = mk(2, 1, 40);
    bus.di[4] = 32'h0000_CCCC;
    step();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    clr_exp();
    check_outs("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    check_outs("hold_flushed");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
